pic_irq_sequencer: RTL and testbench

Interrupt delivery controller of the PIC, sitting between the interrupt priority encoder and the CPU interface. It takes the encoder's current winner (priority level plus index within the level) and raises the CPU request. It runs the acknowledge handshake, tells the source logic which pending bit to clear, and keeps the per-level in-service state used for nesting. A new interrupt is only presented when its priority is strictly higher than the highest level currently in service.

---
 rtl/pic_pkg.sv | 15 +
 rtl/priority_encoder.sv | 23 ++
 rtl/pic_irq_sequencer.sv | 114 +++++++++++
 tb/tb_pic_irq_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and widths for the PIC interrupt delivery path.
package pic_pkg;

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  localparam int PRIO_W = 3;
  localparam int IDX_W  = 3;
  localparam int VEC_W  = PRIO_W + IDX_W;

  typedef struct packed {
    logic [PRIO_W-1:0] prio;
    logic [IDX_W-1:0]  idx;
  } vec_t;

endpackage

// File: rtl/priority_encoder.sv
// Returns the index of the highest set bit of req, plus a flag for "any bit set".
module priority_encoder #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int W = $clog2(N);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx   = i[W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic_irq_sequencer.sv
// Interrupt delivery controller: raises the CPU request for an eligible encoder
// winner, runs the acknowledge handshake and tracks per-level in-service state.
module pic_irq_sequencer
  import pic_pkg::*;
#(
  parameter int NPRIO = 1 << PRIO_W,
  parameter int NIRQ  = 1 << IDX_W
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    enable_i,
  input  logic                                    winner_valid_i,
  input  logic [$clog2(NPRIO)-1:0]                winner_prio_i,
  input  logic [$clog2(NIRQ)-1:0]                 winner_idx_i,
  output logic                                    cpu_irq_o,
  input  logic                                    cpu_ack_i,
  output logic [$clog2(NPRIO)+$clog2(NIRQ)-1:0]   vector_o,
  output logic                                    vector_valid_o,
  output logic                                    pend_clr_o,
  input  logic                                    eoi_i,
  output logic [NPRIO-1:0]                        isr_o
);

  localparam int PW = $clog2(NPRIO);
  localparam int IW = $clog2(NIRQ);

  state_t          state_q, state_d;
  logic [PW-1:0]   lat_prio_q;
  logic [IW-1:0]   lat_idx_q;
  logic [PW+IW-1:0] vector_q;
  logic            vector_valid_q;
  logic            pend_clr_q;
  logic            hold_q;
  logic [NPRIO-1:0] isr_q, isr_d;
  logic [PW-1:0]   cur_level;
  logic            cur_valid;
  logic            eligible;
  logic            deliver;
  logic            latch;

  priority_encoder #(.N(NPRIO)) u_isr_enc (
    .req   (isr_q),
    .idx   (cur_level),
    .valid (cur_valid)
  );

  assign eligible = enable_i && winner_valid_i &&
                    (!cur_valid || (winner_prio_i > cur_level));

  // hold_q keeps IDLE for one extra cycle after a delivery so the cleared
  // pending bit reaches the encoder before the next winner is sampled.
  always_comb begin
    state_d = state_q;
    deliver = 1'b0;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eligible && !hold_q) begin
          state_d = ST_REQ;
          latch   = 1'b1;
        end
      end
      ST_REQ: begin
        if (cpu_ack_i) begin
          deliver = 1'b1;
          state_d = ST_IDLE;
        end else if (!eligible) begin
          state_d = ST_IDLE;
        end else if (winner_prio_i > lat_prio_q) begin
          latch = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // EOI clears the pre-edge top bit first, so a same-cycle delivery wins.
  always_comb begin
    isr_d = isr_q;
    if (eoi_i && cur_valid) isr_d[cur_level] = 1'b0;
    if (deliver)            isr_d[lat_prio_q] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      lat_prio_q     <= '0;
      lat_idx_q      <= '0;
      vector_q       <= '0;
      vector_valid_q <= 1'b0;
      pend_clr_q     <= 1'b0;
      hold_q         <= 1'b0;
      isr_q          <= '0;
    end else begin
      state_q        <= state_d;
      vector_valid_q <= deliver;
      pend_clr_q     <= deliver;
      hold_q         <= deliver;
      isr_q          <= isr_d;
      if (deliver) vector_q <= {lat_prio_q, lat_idx_q};
      if (latch) begin
        lat_prio_q <= winner_prio_i;
        lat_idx_q  <= winner_idx_i;
      end
    end
  end

  assign cpu_irq_o      = (state_q == ST_REQ);
  assign vector_o       = vector_q;
  assign vector_valid_o = vector_valid_q;
  assign pend_clr_o     = pend_clr_q;
  assign isr_o          = isr_q;

endmodule

// File: tb/tb_pic_irq_sequencer.sv
// Directed bench for pic_irq_sequencer with hand-computed expectations.
module tb_pic_irq_sequencer;
  import pic_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       enable_i;
  logic       winner_valid_i;
  logic [2:0] winner_prio_i;
  logic [2:0] winner_idx_i;
  logic       cpu_irq_o;
  logic       cpu_ack_i;
  logic [5:0] vector_o;
  logic       vector_valid_o;
  logic       pend_clr_o;
  logic       eoi_i;
  logic [7:0] isr_o;

  int checks = 0;
  int errors = 0;

  pic_irq_sequencer #(.NPRIO(8), .NIRQ(8)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .winner_valid_i (winner_valid_i),
    .winner_prio_i  (winner_prio_i),
    .winner_idx_i   (winner_idx_i),
    .cpu_irq_o      (cpu_irq_o),
    .cpu_ack_i      (cpu_ack_i),
    .vector_o       (vector_o),
    .vector_valid_o (vector_valid_o),
    .pend_clr_o     (pend_clr_o),
    .eoi_i          (eoi_i),
    .isr_o          (isr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] vec(input int p, input int i);
    vec_t t;
    t.prio = p[2:0];
    t.idx  = i[2:0];
    return t;
  endfunction

  task automatic win(input logic v, input int p, input int i);
    winner_valid_i = v;
    winner_prio_i  = p[2:0];
    winner_idx_i   = i[2:0];
  endtask

  initial begin
    rst_ni = 1'b0; enable_i = 1'b0; cpu_ack_i = 1'b0; eoi_i = 1'b0;
    win(1'b0, 0, 0);
    #2;
    check("rst_irq", cpu_irq_o, 0);
    check("rst_vec", vector_o, 0);
    check("rst_vv", vector_valid_o, 0);
    check("rst_pc", pend_clr_o, 0);
    check("rst_isr", isr_o, 0);
    step(); step();
    rst_ni = 1'b1;
    enable_i = 1'b1;

    // Single request, ack two cycles after the request rises
    win(1'b1, 3, 5);
    step(); check("single_irq", cpu_irq_o, 1);
    step(); check("single_irq_hold", cpu_irq_o, 1);
    cpu_ack_i = 1'b1;
    step();
    check("single_vec", vector_o, 6'h1D);
    check("single_vv", vector_valid_o, 1);
    check("single_pc", pend_clr_o, 1);
    check("single_isr", isr_o, 8'h08);
    check("single_irq_fall", cpu_irq_o, 0);
    cpu_ack_i = 1'b0; win(1'b0, 0, 0);
    step();
    check("single_vv_pulse", vector_valid_o, 0);
    check("single_pc_pulse", pend_clr_o, 0);
    check("single_vec_hold", vector_o, 6'h1D);
    eoi_i = 1'b1;
    step(); check("single_eoi", isr_o, 8'h00);
    eoi_i = 1'b0;

    // Nesting
    win(1'b1, 2, 0);
    step(); check("nest_irq1", cpu_irq_o, 1);
    cpu_ack_i = 1'b1;
    step(); check("nest_vec1", vector_o, vec(2, 0)); check("nest_isr1", isr_o, 8'h04);
    cpu_ack_i = 1'b0; win(1'b1, 6, 1);
    step(); check("nest_gap", cpu_irq_o, 0);
    step(); check("nest_irq2", cpu_irq_o, 1);
    cpu_ack_i = 1'b1;
    step(); check("nest_vec2", vector_o, 6'h31); check("nest_isr2", isr_o, 8'h44);
    cpu_ack_i = 1'b0; win(1'b1, 4, 0);
    step(); step(); step(); check("nest_block4", cpu_irq_o, 0);
    eoi_i = 1'b1;
    step(); check("nest_eoi", isr_o, 8'h04); check("nest_still_low", cpu_irq_o, 0);
    eoi_i = 1'b0;
    step(); check("nest_irq3", cpu_irq_o, 1);
    win(1'b0, 4, 0);
    step(); check("nest_cancel", cpu_irq_o, 0);
    eoi_i = 1'b1;
    step(); check("nest_eoi2", isr_o, 8'h00);
    eoi_i = 1'b0;

    // Blocking at isr = 0x20
    win(1'b1, 5, 0);
    step(); cpu_ack_i = 1'b1;
    step(); check("blk_isr", isr_o, 8'h20);
    cpu_ack_i = 1'b0;
    step(); step(); step(); check("blk_same", cpu_irq_o, 0);
    win(1'b1, 1, 0);
    step(); step(); check("blk_lower", cpu_irq_o, 0);
    win(1'b0, 0, 0); eoi_i = 1'b1;
    step(); check("blk_eoi", isr_o, 8'h00);
    eoi_i = 1'b0;

    // Re-latch to a higher winner while requesting
    win(1'b1, 2, 3);
    step(); check("relatch_irq", cpu_irq_o, 1);
    win(1'b1, 7, 0);
    step(); check("relatch_irq_hold", cpu_irq_o, 1);
    cpu_ack_i = 1'b1;
    step(); check("relatch_vec", vector_o, 6'h38); check("relatch_isr", isr_o, 8'h80);
    cpu_ack_i = 1'b0; win(1'b0, 0, 0); eoi_i = 1'b1;
    step(); check("relatch_eoi", isr_o, 8'h00);
    eoi_i = 1'b0;

    // Cancel: winner withdrawn before ack
    win(1'b1, 4, 2);
    step(); check("cancel_irq", cpu_irq_o, 1);
    win(1'b0, 4, 2);
    step(); check("cancel_fall", cpu_irq_o, 0); check("cancel_vv", vector_valid_o, 0);
    step(); check("cancel_vv2", vector_valid_o, 0); check("cancel_pc", pend_clr_o, 0);
    check("cancel_vec_hold", vector_o, 6'h38); check("cancel_isr", isr_o, 8'h00);

    // Ack and EOI together with isr = 0x10, delivering prio 6
    win(1'b1, 4, 1);
    step(); cpu_ack_i = 1'b1;
    step(); check("sim_isr10", isr_o, 8'h10); check("sim_vec21", vector_o, 6'h21);
    cpu_ack_i = 1'b0; win(1'b1, 6, 2);
    step(); step(); check("sim_irq", cpu_irq_o, 1);
    cpu_ack_i = 1'b1; eoi_i = 1'b1;
    step(); check("sim_isr40", isr_o, 8'h40); check("sim_vec32", vector_o, 6'h32);
    cpu_ack_i = 1'b0; eoi_i = 1'b0; win(1'b0, 0, 0);
    eoi_i = 1'b1;
    step(); check("sim_eoi", isr_o, 8'h00);
    eoi_i = 1'b0;

    // Ack with winner withdrawn in the same cycle
    win(1'b1, 1, 7);
    step(); check("wd_irq", cpu_irq_o, 1);
    cpu_ack_i = 1'b1; win(1'b0, 1, 7);
    step(); check("wd_vec", vector_o, 6'h0F); check("wd_vv", vector_valid_o, 1);
    check("wd_isr", isr_o, 8'h02);
    cpu_ack_i = 1'b0; eoi_i = 1'b1;
    step(); check("wd_eoi", isr_o, 8'h00);
    eoi_i = 1'b0;

    // Asynchronous reset mid-handshake
    win(1'b1, 2, 0);
    step(); cpu_ack_i = 1'b1;
    step(); cpu_ack_i = 1'b0; win(1'b1, 3, 2);
    step(); step(); check("ar_irq", cpu_irq_o, 1); check("ar_isr_pre", isr_o, 8'h04);
    #2 rst_ni = 1'b0;
    #1;
    check("ar_irq_low", cpu_irq_o, 0); check("ar_isr", isr_o, 8'h00);
    check("ar_vec", vector_o, 6'h00); check("ar_vv", vector_valid_o, 0);
    #2 rst_ni = 1'b1;

    // Global enable low blocks requests; ack in IDLE ignored
    enable_i = 1'b0; win(1'b1, 7, 7);
    step(); step(); check("en_off", cpu_irq_o, 0);
    cpu_ack_i = 1'b1;
    step(); check("idle_ack_vv", vector_valid_o, 0); check("idle_ack_isr", isr_o, 8'h00);
    cpu_ack_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
